// File: rtl/tabuleiro_pkg.sv
// Shared types, piece-type codes and geometry helpers for the placement board store.
package tabuleiro_pkg;

  localparam int TAB_DIM        = 8;
  localparam int N_CELULAS      = TAB_DIM * TAB_DIM;
  localparam int N_FROTA_PADRAO = 11;

  typedef enum logic [1:0] {
    EST_IDLE,
    EST_CHECK,
    EST_RESULT,
    EST_WRITE
  } estado_t;

  localparam logic [2:0] TIPO_SUBMARINO    = 3'd1;
  localparam logic [2:0] TIPO_CRUZADOR     = 3'd2;
  localparam logic [2:0] TIPO_HIDROAVIAO   = 3'd3;
  localparam logic [2:0] TIPO_ENCOURACADO  = 3'd4;
  localparam logic [2:0] TIPO_PORTA_AVIOES = 3'd5;

  // Length 0 marks an illegal type code.
  function automatic logic [2:0] len_navio(input logic [2:0] tipo);
    case (tipo)
      TIPO_SUBMARINO:    len_navio = 3'd1;
      TIPO_CRUZADOR:     len_navio = 3'd2;
      TIPO_HIDROAVIAO:   len_navio = 3'd3;
      TIPO_ENCOURACADO:  len_navio = 3'd4;
      TIPO_PORTA_AVIOES: len_navio = 3'd5;
      default:           len_navio = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/celula_navio.sv
// Combinational geometry: k-th cell of a piece from its anchor, off-board flag and
// the board indices of its four orthogonal neighbours.
module celula_navio (
  input  logic            [2:0] x1,
  input  logic            [2:0] y1,
  input  logic                  direcao,
  input  logic                  orientacao,
  input  logic            [2:0] k,
  output logic            [2:0] x,
  output logic            [2:0] y,
  output logic                  fora,
  output logic [3:0]      [5:0] viz_idx,
  output logic            [3:0] viz_ok
);

  logic signed [3:0] passo;
  logic signed [3:0] xs;
  logic signed [3:0] ys;

  always_comb begin
    passo = orientacao ? -$signed({1'b0, k}) : $signed({1'b0, k});
    xs    = $signed({1'b0, x1});
    ys    = $signed({1'b0, y1});
    if (direcao) ys = ys + passo;
    else         xs = xs + passo;
    // Sweep stays within -4..11, so bit 3 alone flags anything outside 0..7.
    fora = xs[3] | ys[3];
    x    = xs[2:0];
    y    = ys[2:0];

    viz_idx[0] = {y, x - 3'd1};
    viz_idx[1] = {y, x + 3'd1};
    viz_idx[2] = {y - 3'd1, x};
    viz_idx[3] = {y + 3'd1, x};
    viz_ok[0]  = !fora && (x != 3'd0);
    viz_ok[1]  = !fora && (x != 3'd7);
    viz_ok[2]  = !fora && (y != 3'd0);
    viz_ok[3]  = !fora && (y != 3'd7);
  end

endmodule

// File: rtl/verifica_armazena_peca.sv
// Board store and conflict checker for the placement phase. Defining
// TABULEIRO_ADJACENCIA_EN also rejects pieces touching an occupied orthogonal neighbour.
module verifica_armazena_peca
  import tabuleiro_pkg::*;
#(
  parameter int N_FROTA = N_FROTA_PADRAO
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valida,
  input  logic            ready,
  input  logic [2:0]      tipo,
  input  logic            jogador,
  input  logic [2:0]      X1,
  input  logic [2:0]      Y1,
  input  logic            direcao,
  input  logic            orientacao,
  input  logic            rd_jogador,
  input  logic [2:0]      rd_x,
  input  logic [2:0]      rd_y,
  output logic            conflito,
  output logic            verificado,
  output logic            gravado,
  output logic            ocupado,
  output logic [1:0][3:0] qtd_pecas,
  output logic [1:0]      completo,
  output logic            rd_celula
);

`ifdef TABULEIRO_ADJACENCIA_EN
  localparam bit ADJ_EN = 1'b1;
`else
  localparam bit ADJ_EN = 1'b0;
`endif

  localparam logic [3:0] FROTA = 4'(N_FROTA);

  estado_t                     estado_q, estado_d;
  logic                        jog_q, jog_d;
  logic [2:0]                  x1_q, x1_d, y1_q, y1_d;
  logic                        dir_q, dir_d, ori_q, ori_d;
  logic [2:0]                  len_q, len_d, k_q, k_d;
  logic                        erro_q, erro_d;
  logic [N_CELULAS-1:0]        mask_q, mask_d;
  logic                        pendente_q, pendente_d;
  logic [1:0][N_CELULAS-1:0]   tab_q, tab_d;
  logic [1:0][3:0]             qtd_q, qtd_d;
  logic                        conflito_q, conflito_d;
  logic                        verificado_q, verificado_d;
  logic                        gravado_q, gravado_d;
  logic                        rd_celula_q, rd_celula_d;

  logic [2:0]       len_in;
  logic [2:0]       cel_x, cel_y;
  logic             cel_fora;
  logic [5:0]       cel_idx;
  logic [3:0][5:0]  viz_idx;
  logic [3:0]       viz_ok;
  logic             ocup_cel, viz_ocup, erro_cel, ultima, pode_gravar;
  logic [1:0]       completo_w;

  celula_navio u_celula (
    .x1         (x1_q),
    .y1         (y1_q),
    .direcao    (dir_q),
    .orientacao (ori_q),
    .k          (k_q),
    .x          (cel_x),
    .y          (cel_y),
    .fora       (cel_fora),
    .viz_idx    (viz_idx),
    .viz_ok     (viz_ok)
  );

  assign len_in     = len_navio(tipo);
  assign cel_idx    = {cel_y, cel_x};
  assign completo_w = {qtd_q[1] == FROTA, qtd_q[0] == FROTA};

  always_comb begin
    ocup_cel = !cel_fora && tab_q[jog_q][cel_idx];
    viz_ocup = 1'b0;
    for (int i = 0; i < 4; i++)
      if (viz_ok[i] && tab_q[jog_q][viz_idx[i]]) viz_ocup = 1'b1;
    erro_cel    = cel_fora | ocup_cel | (ADJ_EN & viz_ocup);
    ultima      = (k_q == len_q - 3'd1);
    pode_gravar = ready && pendente_q && !completo_w[jog_q];
  end

  always_ff @(posedge clk) begin
    if (reset) estado_q <= EST_IDLE;
    else       estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      EST_IDLE: begin
        if (valida)           estado_d = (len_in == 3'd0) ? EST_RESULT : EST_CHECK;
        else if (pode_gravar) estado_d = EST_WRITE;
      end
      EST_CHECK:  if (ultima) estado_d = EST_RESULT;
      EST_RESULT: estado_d = EST_IDLE;
      EST_WRITE:  estado_d = EST_IDLE;
      default:    estado_d = EST_IDLE;
    endcase
  end

  always_comb begin
    jog_d        = jog_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    dir_d        = dir_q;
    ori_d        = ori_q;
    len_d        = len_q;
    k_d          = k_q;
    erro_d       = erro_q;
    mask_d       = mask_q;
    pendente_d   = pendente_q;
    tab_d        = tab_q;
    qtd_d        = qtd_q;
    conflito_d   = conflito_q;
    verificado_d = 1'b0;
    gravado_d    = 1'b0;
    rd_celula_d  = tab_q[rd_jogador][{rd_y, rd_x}];
    case (estado_q)
      EST_IDLE: begin
        if (valida) begin
          jog_d      = jogador;
          x1_d       = X1;
          y1_d       = Y1;
          dir_d      = direcao;
          ori_d      = orientacao;
          len_d      = len_in;
          k_d        = 3'd0;
          erro_d     = (len_in == 3'd0);
          mask_d     = '0;
          pendente_d = 1'b0;
        end
      end
      EST_CHECK: begin
        erro_d = erro_q | erro_cel;
        if (!cel_fora) mask_d[cel_idx] = 1'b1;
        k_d = k_q + 3'd1;
      end
      EST_RESULT: begin
        conflito_d   = erro_q;
        verificado_d = 1'b1;
        pendente_d   = !erro_q;
      end
      EST_WRITE: begin
        tab_d[jog_q] = tab_q[jog_q] | mask_q;
        qtd_d[jog_q] = qtd_q[jog_q] + 4'd1;
        gravado_d    = 1'b1;
        pendente_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pendente_q   <= 1'b0;
      tab_q        <= '0;
      qtd_q        <= '0;
      conflito_q   <= 1'b0;
      verificado_q <= 1'b0;
      gravado_q    <= 1'b0;
      rd_celula_q  <= 1'b0;
    end else begin
      pendente_q   <= pendente_d;
      tab_q        <= tab_d;
      qtd_q        <= qtd_d;
      conflito_q   <= conflito_d;
      verificado_q <= verificado_d;
      gravado_q    <= gravado_d;
      rd_celula_q  <= rd_celula_d;
    end
  end

  // Latched piece fields are only meaningful after a request, so they carry no reset.
  always_ff @(posedge clk) begin
    jog_q  <= jog_d;
    x1_q   <= x1_d;
    y1_q   <= y1_d;
    dir_q  <= dir_d;
    ori_q  <= ori_d;
    len_q  <= len_d;
    k_q    <= k_d;
    erro_q <= erro_d;
    mask_q <= mask_d;
  end

  assign conflito   = conflito_q;
  assign verificado = verificado_q;
  assign gravado    = gravado_q;
  assign ocupado    = (estado_q != EST_IDLE);
  assign qtd_pecas  = qtd_q;
  assign completo   = completo_w;
  assign rd_celula  = rd_celula_q;

endmodule

// File: tb/tb_verifica_armazena_peca.sv
// Self-checking bench for verifica_armazena_peca against a cell-level board model.
module tb_verifica_armazena_peca;

`ifdef TABULEIRO_ADJACENCIA_EN
  localparam bit ADJ = 1'b1;
`else
  localparam bit ADJ = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset, valida, ready;
  logic [2:0]      tipo, X1, Y1, rd_x, rd_y;
  logic            jogador, direcao, orientacao, rd_jogador;
  logic            conflito, verificado, gravado, ocupado, rd_celula;
  logic [1:0][3:0] qtd_pecas;
  logic [1:0]      completo;

  verifica_armazena_peca dut (
    .clk(clk), .reset(reset), .valida(valida), .ready(ready), .tipo(tipo),
    .jogador(jogador), .X1(X1), .Y1(Y1), .direcao(direcao), .orientacao(orientacao),
    .rd_jogador(rd_jogador), .rd_x(rd_x), .rd_y(rd_y), .conflito(conflito),
    .verificado(verificado), .gravado(gravado), .ocupado(ocupado),
    .qtd_pecas(qtd_pecas), .completo(completo), .rd_celula(rd_celula)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic checa(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: occupancy per player/cell, counts, pending piece.
  bit          mb[2][64];
  int          mq[2];
  bit          pend;
  int          pj;
  logic [63:0] pmask;

  function automatic void modelo_limpa();
    for (int j = 0; j < 2; j++) begin
      mq[j] = 0;
      for (int i = 0; i < 64; i++) mb[j][i] = 1'b0;
    end
    pend = 1'b0;
  endfunction

`ifdef TABULEIRO_ADJACENCIA_EN
  function automatic bit ocup(int j, int x, int y);
    if (x < 0 || x > 7 || y < 0 || y > 7) return 1'b0;
    return mb[j][y*8+x];
  endfunction
`endif

  function automatic bit modelo(input int t, input int j, input int x, input int y,
                                input int d, input int o, output logic [63:0] m);
    int len, cx, cy;
    bit e;
    m   = '0;
    e   = 1'b0;
    len = (t >= 1 && t <= 5) ? t : 0;
    if (len == 0) return 1'b1;
    for (int k = 0; k < len; k++) begin
      cx = x + ((d == 0) ? (o != 0 ? -k : k) : 0);
      cy = y + ((d == 1) ? (o != 0 ? -k : k) : 0);
      if (cx < 0 || cx > 7 || cy < 0 || cy > 7) e = 1'b1;
      else begin
        if (mb[j][cy*8+cx]) e = 1'b1;
`ifdef TABULEIRO_ADJACENCIA_EN
        if (ocup(j, cx-1, cy) || ocup(j, cx+1, cy) || ocup(j, cx, cy-1) || ocup(j, cx, cy+1))
          e = 1'b1;
`endif
        m[cy*8+cx] = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic verificar(input int t, input int j, input int x, input int y,
                           input int d, input int o);
    logic [63:0] m;
    bit e, achou;
    int lat, n;
    e   = modelo(t, j, x, y, d, o, m);
    lat = (t >= 1 && t <= 5) ? t + 1 : 1;
    @(negedge clk);
    tipo = t[2:0]; jogador = j[0]; X1 = x[2:0]; Y1 = y[2:0];
    direcao = d[0]; orientacao = o[0]; valida = 1'b1;
    @(posedge clk); #1;
    valida     = 1'b0;
    tipo       = 3'($urandom_range(0, 7));
    jogador    = 1'($urandom_range(0, 1));
    X1         = 3'($urandom_range(0, 7));
    Y1         = 3'($urandom_range(0, 7));
    direcao    = 1'($urandom_range(0, 1));
    orientacao = 1'($urandom_range(0, 1));
    checa("ocupado_check", ocupado, 1);
    achou = 1'b0;
    n = 0;
    while (!achou && n < 12) begin
      @(posedge clk); #1;
      n++;
      achou = verificado;
    end
    checa("verificado_timeout", achou, 1);
    checa("latencia", n, lat);
    checa("conflito", conflito, e);
    checa("ocupado_idle", ocupado, 0);
    @(posedge clk); #1;
    checa("verificado_pulso", verificado, 0);
    checa("conflito_mantido", conflito, e);
    pend  = !e;
    pj    = j;
    pmask = m;
  endtask

  task automatic gravar();
    bit w;
    w = pend && (mq[pj] != 11);
    @(negedge clk);
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    checa("ocupado_write", ocupado, w);
    @(posedge clk); #1;
    checa("gravado", gravado, w);
    if (w) begin
      for (int i = 0; i < 64; i++) if (pmask[i]) mb[pj][i] = 1'b1;
      mq[pj]++;
      pend = 1'b0;
    end
    checa("qtd0", qtd_pecas[0], mq[0]);
    checa("qtd1", qtd_pecas[1], mq[1]);
    checa("completo", completo, {mq[1] == 11, mq[0] == 11});
  endtask

  task automatic ler(input int j, input int x, input int y);
    @(negedge clk);
    rd_jogador = j[0]; rd_x = x[2:0]; rd_y = y[2:0];
    @(posedge clk); #1;
    checa("rd_celula", rd_celula, mb[j][y*8+x]);
  endtask

  task automatic varrer();
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 64; i++) ler(j, i % 8, i / 8);
  endtask

  task automatic checa_zeros(input string tag);
    checa(tag, {conflito, verificado, gravado, ocupado, qtd_pecas, completo, rd_celula}, 0);
  endtask

  initial begin
    reset = 1'b1; valida = 1'b0; ready = 1'b0; tipo = 3'd0; jogador = 1'b0;
    X1 = 3'd0; Y1 = 3'd0; direcao = 1'b0; orientacao = 1'b0;
    rd_jogador = 1'b0; rd_x = 3'd0; rd_y = 3'd0;
    modelo_limpa();
    repeat (3) @(posedge clk);
    #1;
    checa_zeros("reset_saidas");
    @(negedge clk);
    reset = 1'b0;

    // Clean submarino, then commit
    verificar(1, 0, 3, 4, 0, 0);
    checa("sub_limpo", conflito, 0);
    gravar();
    ler(0, 3, 4);

    // Horizontal overlap; commit must be ignored
    verificar(5, 0, 0, 4, 0, 0);
    checa("sobreposicao", conflito, 1);
    gravar();

    // Bounds wrap, then mirrored orientation
    verificar(4, 0, 6, 0, 0, 0);
    checa("fora_limite", conflito, 1);
    verificar(4, 0, 6, 0, 0, 1);
    checa("orient_neg", conflito, 0);
    gravar();
    for (int x = 2; x < 8; x++) ler(0, x, 0);

    // Player isolation and illegal type
    verificar(1, 1, 3, 4, 0, 0);
    checa("isolamento", conflito, 0);
    gravar();
    verificar(7, 0, 0, 0, 0, 0);
    checa("tipo_ilegal", conflito, 1);
    gravar();

    // Neighbour of (3,4)
    verificar(1, 0, 3, 5, 1, 0);
    checa("adjacencia", conflito, ADJ);

    // Fleet completion on player 1
    for (int i = 0; i < 10; i++) begin
      verificar(1, 1, (i % 4) * 2, (i < 4) ? 0 : ((i < 8) ? 2 : 6), 0, 0);
      gravar();
    end
    checa("frota_qtd", qtd_pecas[1], 11);
    checa("frota_completa", completo[1], 1);
    verificar(1, 1, 4, 6, 0, 0);
    gravar();
    checa("frota_cheia_qtd", qtd_pecas[1], 11);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) != 0)
        verificar($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1));
      if ($urandom_range(0, 1) != 0) gravar();
      ler($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7));
    end
    varrer();

    // Reset during CHECK aborts everything
    @(negedge clk);
    tipo = 3'd5; jogador = 1'b0; X1 = 3'd0; Y1 = 3'd7;
    direcao = 1'b0; orientacao = 1'b0; valida = 1'b1;
    @(posedge clk); #1;
    valida = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checa_zeros("reset_abort");
    @(negedge clk);
    reset = 1'b0;
    modelo_limpa();
    varrer();
    gravar();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
